// File: rtl/ps2_zx_keyboard.sv
// PS/2 keyboard receiver feeding an 8x5 ZX81 key matrix read through the
// active-low Z80 row select. Handles E0/F0 prefixes and frame checking.
module ps2_zx_keyboard #(
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic [7:0] row_sel_n,
  output logic [4:0] kbd_col_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_ext,
  output logic       frame_err
);

  localparam logic [1:0] PRE_IDLE   = 2'd0;
  localparam logic [1:0] PRE_EXT    = 2'd1;
  localparam logic [1:0] PRE_BRK    = 2'd2;
  localparam logic [1:0] PRE_EXTBRK = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TO_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]      ck_q;
  logic [1:0]      dt_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;
  logic            frame_err_q, frame_err_d;

  logic [1:0]      pre_q, pre_d;
  logic [39:1]     keys_q, keys_d;
  logic            lsh_q, lsh_d, rsh_q, rsh_d;
  logic            key_valid_q, key_valid_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_pressed_q, key_pressed_d;
  logic            key_ext_q, key_ext_d;

  logic            fall, din, is_ext, is_brk, map_hit;
  logic [5:0]      map_idx;
  logic [39:0]     key_mat;
  logic [4:0]      col;

  // ck_q[2] is the previous synchronised clock, ck_q[1] the current one.
  assign fall = ck_q[2] & ~ck_q[1];
  assign din  = dt_q[1];

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    wd_d        = wd_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    if (fall) begin
      wd_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (din) frame_err_d = 1'b1;
        else     bit_cnt_d   = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = din;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        if (din && (par_q ^ (^shift_q))) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wd_q == TO_LAST) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = 4'd0;
        wd_d        = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ck_q        <= 3'b111;
      dt_q        <= 2'b11;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      wd_q        <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      ck_q        <= {ck_q[1:0], ps2_kbd_clk};
      dt_q        <= {dt_q[0], ps2_kbd_data};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign is_ext = (pre_q == PRE_EXT) || (pre_q == PRE_EXTBRK);
  assign is_brk = (pre_q == PRE_BRK) || (pre_q == PRE_EXTBRK);

  // Matrix bit index is row*5 + column; index 0 (Shift) comes from the shift flags.
  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    case (byte_q)
      8'h1A: map_idx = 6'd1;   8'h22: map_idx = 6'd2;
      8'h21: map_idx = 6'd3;   8'h2A: map_idx = 6'd4;
      8'h1C: map_idx = 6'd5;   8'h1B: map_idx = 6'd6;
      8'h23: map_idx = 6'd7;   8'h2B: map_idx = 6'd8;
      8'h34: map_idx = 6'd9;   8'h15: map_idx = 6'd10;
      8'h1D: map_idx = 6'd11;  8'h24: map_idx = 6'd12;
      8'h2D: map_idx = 6'd13;  8'h2C: map_idx = 6'd14;
      8'h16: map_idx = 6'd15;  8'h1E: map_idx = 6'd16;
      8'h26: map_idx = 6'd17;  8'h25: map_idx = 6'd18;
      8'h2E: map_idx = 6'd19;  8'h45: map_idx = 6'd20;
      8'h46: map_idx = 6'd21;  8'h3E: map_idx = 6'd22;
      8'h3D: map_idx = 6'd23;  8'h36: map_idx = 6'd24;
      8'h4D: map_idx = 6'd25;  8'h44: map_idx = 6'd26;
      8'h43: map_idx = 6'd27;  8'h3C: map_idx = 6'd28;
      8'h35: map_idx = 6'd29;  8'h5A: map_idx = 6'd30;
      8'h4B: map_idx = 6'd31;  8'h42: map_idx = 6'd32;
      8'h3B: map_idx = 6'd33;  8'h33: map_idx = 6'd34;
      8'h29: map_idx = 6'd35;  8'h49: map_idx = 6'd36;
      8'h3A: map_idx = 6'd37;  8'h31: map_idx = 6'd38;
      8'h32: map_idx = 6'd39;
      default: map_hit = 1'b0;
    endcase
    if (is_ext && byte_q != 8'h5A) map_hit = 1'b0;
  end

  always_comb begin
    pre_d         = pre_q;
    keys_d        = keys_q;
    lsh_d         = lsh_q;
    rsh_d         = rsh_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    key_ext_d     = key_ext_q;
    if (byte_vld_q) begin
      case (byte_q)
        8'hE0: begin
          if (pre_q == PRE_IDLE)     pre_d = PRE_EXT;
          else if (pre_q == PRE_BRK) pre_d = PRE_EXTBRK;
        end
        8'hF0: begin
          if (pre_q == PRE_IDLE)     pre_d = PRE_BRK;
          else if (pre_q == PRE_EXT) pre_d = PRE_EXTBRK;
        end
        8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
        default: begin
          key_valid_d   = 1'b1;
          key_code_d    = byte_q;
          key_pressed_d = ~is_brk;
          key_ext_d     = is_ext;
          pre_d         = PRE_IDLE;
          if (!is_ext && byte_q == 8'h12)      lsh_d = ~is_brk;
          else if (!is_ext && byte_q == 8'h59) rsh_d = ~is_brk;
          else if (map_hit)                    keys_d[map_idx] = ~is_brk;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pre_q         <= PRE_IDLE;
      keys_q        <= '0;
      lsh_q         <= 1'b0;
      rsh_q         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_pressed_q <= 1'b0;
      key_ext_q     <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      keys_q        <= keys_d;
      lsh_q         <= lsh_d;
      rsh_q         <= rsh_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      key_ext_q     <= key_ext_d;
    end
  end

  assign key_mat = {keys_q, lsh_q | rsh_q};

  always_comb begin
    col = 5'd0;
    for (int r = 0; r < 8; r++) begin
      if (!row_sel_n[r]) col = col | key_mat[r*5 +: 5];
    end
  end

  assign kbd_col_n   = ~col;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign key_ext     = key_ext_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/ps2_zx_keyboard.md
Name: ps2_zx_keyboard

Overview:
- Downstream consumer of the MiST I/O block's emulated PS/2 keyboard lines (ps2_kbd_clk / ps2_kbd_data).
- Deserialises PS/2 device-to-host frames, checks them, and tracks E0/F0 prefixes.
- Maintains key state in the 8x5 ZX81 keyboard matrix.
- The ULA-side logic reads columns through the active-low row select taken from Z80 A[15:8].

Parameters:
- TIMEOUT, 20000: clk_sys cycles without a PS/2 falling edge, while mid-frame, before the frame is aborted.

Ports:
- clk_sys  in  1  system clock; the PS/2 lines are generated from it but are still treated as asynchronous.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_kbd_clk  in  1  PS/2 clock; idles high.
- ps2_kbd_data  in  1  PS/2 data.
- row_sel_n  in  8  active-low row select (Z80 A[15:8]); bit r selects row r.
- kbd_col_n  out  5  active-low column data; bit 0 is nearest the row's first key.
- key_valid  out  1  one-cycle pulse per decoded make/break event.
- key_code  out  8  scancode for the key_valid event.
- key_pressed  out  1  1 = make, 0 = break; valid with key_valid.
- key_ext  out  1  E0 prefix seen; valid with key_valid.
- frame_err  out  1  one-cycle pulse on a bad start/parity/stop bit or a timeout.

Behaviour:
Reset (async, reset_n=0):
- Bit counter 0, FSM PRE_IDLE, all keys released, kbd_col_n=5'h1F.
- key_valid=0, frame_err=0, key_code=0, key_pressed=0, key_ext=0.
- Synchronisers are preset to 1.
- Reset asserted mid-frame discards the partial frame. No event is emitted.

Input sampling and frame capture:
- ps2_kbd_clk and ps2_kbd_data each pass through a 2-FF synchroniser.
- A falling edge is detected as previous synchronised clock = 1 and current = 0. Data is sampled in the same cycle.
- Frame is 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). bit_cnt runs 0..10.
- Start bit = 1 at bit_cnt=0: frame_err pulses and bit_cnt stays 0 (resynchronise).
- On the stop bit, the frame is accepted only if parity ^ (XOR of d0..d7) = 1 and stop = 1. Otherwise frame_err pulses and the byte is dropped.
- bit_cnt returns to 0 after the stop bit in either case.
- Watchdog counts while bit_cnt != 0 and resets on each falling edge. At TIMEOUT it pulses frame_err and sets bit_cnt to 0.
- Accepted byte reaches the prefix FSM 1 cycle after the stop-bit edge.
- key_valid and matrix update occur 2 cycles after the stop-bit edge.

Prefix FSM (states PRE_IDLE, PRE_EXT, PRE_BRK, PRE_EXTBRK):
- E0: PRE_IDLE→PRE_EXT; PRE_BRK→PRE_EXTBRK.
- F0: PRE_IDLE→PRE_BRK; PRE_EXT→PRE_EXTBRK.
- E1 and FA/AA/EE/FE: ignored, no state change.
- Any other byte:
  - key_valid pulses with key_code=byte.
  - key_pressed=0 in the BRK states, 1 otherwise.
  - key_ext=1 in the EXT states, 0 otherwise.
  - FSM returns to PRE_IDLE.
- Repeated E0 or F0 in an already-prefixed state is absorbed.

Matrix (row: cols 0..4, non-extended scancodes):
- r0: Shift(12 or 59) Z1A X22 C21 V2A
- r1: A1C S1B D23 F2B G34
- r2: Q15 W1D E24 R2D T2C
- r3: 1:16 2:1E 3:26 4:25 5:2E
- r4: 0:45 9:46 8:3E 7:3D 6:36
- r5: P4D O44 I43 U3C Y35
- r6: Enter5A L4B K42 J3B H33
- r7: Space29 .49 M3A N31 B32
- Extended E0 5A maps to Enter. All other extended codes and unmapped codes only produce key_valid.

Key state:
- Make sets the key bit; break clears it. Typematic repeat of a make is idempotent.
- Left and right shift are held in separate flags. The Shift matrix bit is their OR, so releasing one shift while the other is held keeps Shift down.

Column read:
- kbd_col_n[c] = ~OR over r (row_sel_n[r]==0 AND key[r][c]). Combinational, zero latency.
- Multiple rows selected are ORed. No rows selected gives 1F.

Test Plan:
- Send frame 1C (parity 0) → key_valid with key_code=1C, key_pressed=1, key_ext=0. row_sel_n=FD gives kbd_col_n=1E; row_sel_n=FF gives 1F.
- Send F0,1C → key_pressed=0 event; row_sel_n=FD gives 1F. Second make 1C,1C → row FD gives 1E, with no extra state change.
- Send 12, 59, F0 12 → row_sel_n=FE gives kbd_col_n=1E (Shift still held). Then F0 59 → 1F.
- Send E0 5A → key_ext=1 and row_sel_n=BF gives 1E. Then E0 F0 5A → 1F. Send E0 75 → key_valid only, matrix unchanged.
- Frame 1C with wrong parity bit → frame_err pulse, no key_valid, matrix unchanged. Next good frame 1B → row FD gives 1D.
- Stop clocking after 4 bits for TIMEOUT cycles → frame_err pulse, then full frame 29 decodes correctly (row 7F gives 1E). reset_n low mid-frame → all outputs at reset values.
